// File: rtl/mem_lsu_pkg.sv
// Shared LSU definitions: funct3 access codes, FSM encodings
// and the local misaligned/illegal access check.
package mem_lsu_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  function automatic logic lsu_bad(
    input logic [2:0] f3,
    input logic       we,
    input logic [1:0] a
  );
    logic ill;
    logic mis;
    case (f3)
      LSU_B, LSU_H, LSU_W: ill = 1'b0;
      LSU_BU, LSU_HU:      ill = we;
      default:             ill = 1'b1;
    endcase
    mis = (f3[1:0] == 2'b01 && a[0]) ||
          (f3[1:0] == 2'b10 && a != 2'b00);
    return ill | mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: store strobes/replicated data and
// load extraction with sign/zero extension. Purely combinational.
module lsu_align
  import mem_lsu_pkg::*;
(
  input  logic [2:0]  i_f3,
  input  logic [1:0]  i_a,
  input  logic [31:0] i_sdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ldata
);

  logic [31:0] w_sh;

  assign w_sh = i_rdata >> {i_a, 3'b000};

  always_comb begin
    o_wstrb = 4'b0000;
    o_wdata = i_sdata;
    case (i_f3[1:0])
      2'b00: begin
        o_wstrb = 4'b0001 << i_a;
        o_wdata = {4{i_sdata[7:0]}};
      end
      2'b01: begin
        o_wstrb = 4'b0011 << i_a;
        o_wdata = {2{i_sdata[15:0]}};
      end
      2'b10: o_wstrb = 4'b1111;
      default: o_wstrb = 4'b0000;
    endcase
  end

  always_comb begin
    o_ldata = '0;
    case (i_f3)
      LSU_B:   o_ldata = {{24{w_sh[7]}}, w_sh[7:0]};
      LSU_H:   o_ldata = {{16{w_sh[15]}}, w_sh[15:0]};
      LSU_W:   o_ldata = i_rdata;
      LSU_BU:  o_ldata = {24'd0, w_sh[7:0]};
      LSU_HU:  o_ldata = {16'd0, w_sh[15:0]};
      default: o_ldata = '0;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: req/gnt/rvalid bus FSM, stall,
// local misalign/illegal detection, aligned load writeback.
module mem_lsu
  import mem_lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_rvalid
);

  lsu_state_e  r_state;
  logic [31:0] r_addr;
  logic [31:0] r_sdata;
  logic [31:0] r_load_data;
  logic [2:0]  r_f3;
  logic        r_we;
  logic        r_kill;
  logic        r_err;

  logic        w_acc;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic [31:0] w_ldata;

  assign w_acc = in_valid & (mem_read | mem_write) & ~flush;

  lsu_align u_align (
    .i_f3    (r_f3),
    .i_a     (r_addr[1:0]),
    .i_sdata (r_sdata),
    .i_rdata (dmem_rdata),
    .o_wstrb (w_wstrb),
    .o_wdata (w_wdata),
    .o_ldata (w_ldata)
  );

  assign stall = (r_state == LSU_REQ) |
                 (r_state == LSU_WAIT) |
                 ((r_state == LSU_IDLE) & w_acc);

  assign done       = (r_state == LSU_DONE);
  assign err        = r_err;
  assign load_data  = r_load_data;
  assign dmem_req   = (r_state == LSU_REQ);
  assign dmem_we    = dmem_req & r_we;
  assign dmem_addr  = {r_addr[31:2], 2'b00};
  assign dmem_wstrb = dmem_we ? w_wstrb : 4'b0000;
  assign dmem_wdata = w_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= LSU_IDLE;
      r_addr      <= '0;
      r_sdata     <= '0;
      r_load_data <= '0;
      r_f3        <= '0;
      r_we        <= 1'b0;
      r_kill      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        LSU_IDLE: begin
          if (w_acc) begin
            r_addr      <= addr;
            r_sdata     <= store_data;
            r_f3        <= funct3;
            r_we        <= mem_write;
            r_kill      <= 1'b0;
            r_load_data <= '0;
            if (lsu_bad(funct3, mem_write, addr[1:0])) begin
              r_err   <= 1'b1;
              r_state <= LSU_DONE;
            end else begin
              r_state <= LSU_REQ;
            end
          end
        end
        LSU_REQ: begin
          // A grant in the flush cycle is already owned by the
          // bus, so its response must still be drained.
          if (dmem_gnt) begin
            r_state <= LSU_WAIT;
            r_kill  <= flush;
          end else if (flush) begin
            r_state <= LSU_IDLE;
          end
        end
        LSU_WAIT: begin
          if (dmem_rvalid) begin
            if (r_kill | flush) begin
              r_state <= LSU_IDLE;
              r_kill  <= 1'b0;
            end else begin
              r_state     <= LSU_DONE;
              r_load_data <= r_we ? '0 : w_ldata;
            end
          end else if (flush) begin
            r_kill <= 1'b1;
          end
        end
        LSU_DONE: begin
          r_state     <= LSU_IDLE;
          r_err       <= 1'b0;
          r_load_data <= '0;
        end
        default: r_state <= LSU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: vector table of single
// accesses plus wait-state, flush and async-reset sequences.
module tb_mem_lsu;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        flush;
  logic        stall;
  logic        done;
  logic [31:0] load_data;
  logic        err;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic [31:0] dmem_rdata;
  logic        dmem_rvalid;

  int checks = 0;
  int errors = 0;

  mem_lsu dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .funct3      (funct3),
    .addr        (addr),
    .store_data  (store_data),
    .flush       (flush),
    .stall       (stall),
    .done        (done),
    .load_data   (load_data),
    .err         (err),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wstrb  (dmem_wstrb),
    .dmem_wdata  (dmem_wdata),
    .dmem_gnt    (dmem_gnt),
    .dmem_rdata  (dmem_rdata),
    .dmem_rvalid (dmem_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] sd;
    logic [31:0] rd;
    int          gdly;
    logic        e_err;
    logic [31:0] e_ld;
    logic [31:0] e_addr;
    logic [3:0]  e_strb;
    logic [31:0] e_wd;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    in_valid    = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    funct3      = 3'b000;
    addr        = '0;
    store_data  = '0;
    flush       = 1'b0;
    dmem_gnt    = 1'b0;
    dmem_rdata  = '0;
    dmem_rvalid = 1'b0;
  endtask

  // Called on a negedge while the DUT is IDLE.
  task automatic present(input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd);
    in_valid   = 1'b1;
    mem_read   = ~wr;
    mem_write  = wr;
    funct3     = f3;
    addr       = a;
    store_data = sd;
  endtask

  task automatic run_vec(input vec_t v);
    present(v.wr, v.f3, v.a, v.sd);
    #1 chk({v.name, " stall@T"}, 32'(stall), 32'd1);
    @(negedge clk);
    idle_inputs();
    if (v.e_err) begin
      chk({v.name, " done"}, 32'(done), 32'd1);
      chk({v.name, " err"}, 32'(err), 32'd1);
      chk({v.name, " ld"}, load_data, 32'd0);
      chk({v.name, " noreq"}, 32'(dmem_req), 32'd0);
    end else begin
      chk({v.name, " req"}, 32'(dmem_req), 32'd1);
      chk({v.name, " we"}, 32'(dmem_we), 32'(v.wr));
      chk({v.name, " addr"}, dmem_addr, v.e_addr);
      chk({v.name, " strb"}, 32'(dmem_wstrb), 32'(v.e_strb));
      if (v.wr) chk({v.name, " wdata"}, dmem_wdata, v.e_wd);
      for (int i = 0; i < v.gdly; i++) begin
        @(negedge clk);
        chk({v.name, " hold req"}, 32'(dmem_req), 32'd1);
        chk({v.name, " hold addr"}, dmem_addr, v.e_addr);
        chk({v.name, " hold wdata"}, dmem_wdata, v.e_wd);
        chk({v.name, " hold stall"}, 32'(stall), 32'd1);
      end
      dmem_gnt = 1'b1;
      @(negedge clk);
      dmem_gnt = 1'b0;
      chk({v.name, " wait req"}, 32'(dmem_req), 32'd0);
      chk({v.name, " wait stall"}, 32'(stall), 32'd1);
      chk({v.name, " wait done"}, 32'(done), 32'd0);
      dmem_rvalid = 1'b1;
      dmem_rdata  = v.rd;
      @(negedge clk);
      idle_inputs();
      chk({v.name, " done"}, 32'(done), 32'd1);
      chk({v.name, " err"}, 32'(err), 32'd0);
      chk({v.name, " ld"}, load_data, v.e_ld);
    end
    chk({v.name, " done stall"}, 32'(stall), 32'd0);
    @(negedge clk);
    chk({v.name, " done pulse"}, 32'(done), 32'd0);
  endtask

  function automatic vec_t mk(string n, logic wr, logic [2:0] f3,
                              logic [31:0] a, logic [31:0] sd,
                              logic [31:0] rd, int gd, logic ee,
                              logic [31:0] ld, logic [3:0] st,
                              logic [31:0] wd);
    vec_t v;
    v.name = n; v.wr = wr; v.f3 = f3; v.a = a; v.sd = sd;
    v.rd = rd; v.gdly = gd; v.e_err = ee; v.e_ld = ld;
    v.e_addr = {a[31:2], 2'b00}; v.e_strb = st; v.e_wd = wd;
    return v;
  endfunction

  initial begin
    vecs[0]  = mk("LW",     0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 4'h0, 0);
    vecs[1]  = mk("LB3",    0, 3'b000, 32'h103, 0, 32'h80FF1234, 0, 0, 32'hFFFFFF80, 4'h0, 0);
    vecs[2]  = mk("LBU3",   0, 3'b100, 32'h103, 0, 32'h80FF1234, 0, 0, 32'h00000080, 4'h0, 0);
    vecs[3]  = mk("LHU2",   0, 3'b101, 32'h102, 0, 32'h80FF1234, 0, 0, 32'h000080FF, 4'h0, 0);
    vecs[4]  = mk("LH2",    0, 3'b001, 32'h102, 0, 32'h80FF1234, 0, 0, 32'hFFFF80FF, 4'h0, 0);
    vecs[5]  = mk("LB0",    0, 3'b000, 32'h100, 0, 32'h80FF1234, 1, 0, 32'h00000034, 4'h0, 0);
    vecs[6]  = mk("SB1",    1, 3'b000, 32'h101, 32'h000000A5, 0, 0, 0, 0, 4'b0010, 32'hA5A5A5A5);
    vecs[7]  = mk("SW",     1, 3'b010, 32'h300, 32'h11223344, 32'hFFFFFFFF, 0, 0, 0, 4'b1111, 32'h11223344);
    vecs[8]  = mk("SH2",    1, 3'b001, 32'h202, 32'h1234ABCD, 0, 3, 0, 0, 4'b1100, 32'hABCDABCD);
    vecs[9]  = mk("LWmis",  0, 3'b010, 32'h101, 0, 0, 0, 1, 0, 4'h0, 0);
    vecs[10] = mk("LHmis",  0, 3'b001, 32'h103, 0, 0, 0, 1, 0, 4'h0, 0);
    vecs[11] = mk("L011",   0, 3'b011, 32'h100, 0, 0, 0, 1, 0, 4'h0, 0);
    vecs[12] = mk("S100",   1, 3'b100, 32'h100, 0, 0, 0, 1, 0, 4'h0, 0);
    vecs[13] = mk("LHUmis", 0, 3'b101, 32'h101, 0, 0, 0, 1, 0, 4'h0, 0);
    vecs[14] = mk("SWmis",  1, 3'b010, 32'h102, 0, 0, 0, 1, 0, 4'h0, 0);

    idle_inputs();
    rst_n = 1'b0;
    #12;
    chk("rst stall", 32'(stall), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst req", 32'(dmem_req), 32'd0);
    chk("rst addr", dmem_addr, 32'd0);
    chk("rst wdata", dmem_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 15; i++) run_vec(vecs[i]);

    // Flush while waiting for the response: drain, no done.
    present(0, 3'b010, 32'h400, 0);
    @(negedge clk);
    idle_inputs();
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fw stall", 32'(stall), 32'd1);
    chk("fw done", 32'(done), 32'd0);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h55555555;
    @(negedge clk);
    idle_inputs();
    chk("fw nodone", 32'(done), 32'd0);
    chk("fw idle stall", 32'(stall), 32'd0);
    @(negedge clk);
    chk("fw nodone2", 32'(done), 32'd0);
    run_vec(vecs[0]);

    // Flush in REQ before grant: request dropped.
    present(0, 3'b010, 32'h500, 0);
    @(negedge clk);
    idle_inputs();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fr req", 32'(dmem_req), 32'd0);
    chk("fr done", 32'(done), 32'd0);
    chk("fr stall", 32'(stall), 32'd0);

    // Flush in IDLE blocks acceptance.
    present(0, 3'b010, 32'h600, 0);
    flush = 1'b1;
    #1 chk("fi stall", 32'(stall), 32'd0);
    @(negedge clk);
    idle_inputs();
    chk("fi noreq", 32'(dmem_req), 32'd0);

    // Async reset while in REQ.
    present(1, 3'b010, 32'h700, 32'hCAFEF00D);
    @(negedge clk);
    idle_inputs();
    chk("ar req", 32'(dmem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar req0", 32'(dmem_req), 32'd0);
    chk("ar we0", 32'(dmem_we), 32'd0);
    chk("ar addr0", dmem_addr, 32'd0);
    chk("ar strb0", 32'(dmem_wstrb), 32'd0);
    chk("ar wdata0", dmem_wdata, 32'd0);
    chk("ar stall0", 32'(stall), 32'd0);
    chk("ar done0", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ar idle", 32'(dmem_req), 32'd0);
    run_vec(vecs[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store unit for the MEM stage of the pipelined core. Consumes the EX-stage ALU result as the effective address, plus store data and access type. Drives a req/gnt/rvalid data-memory port, stalls the pipeline until the access completes, and returns aligned, sign/zero-extended load data to the writeback path. Misaligned and unsupported accesses are detected locally and never reach the bus.

## Interface
Parameters:
- none (32-bit datapath, 4-byte word fixed)

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  MEM-stage instruction valid
- mem_read  in  1  instruction is a load
- mem_write  in  1  instruction is a store (mem_read & mem_write never both 1)
- funct3  in  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 (stores)
- addr  in  32  effective address (ALU result)
- store_data  in  32  rs2 value
- flush  in  1  kill in-flight access (pipeline redirect)
- stall  out  1  hold upstream stages
- done  out  1  one-cycle completion pulse
- load_data  out  32  extended load result, valid while done=1
- err  out  1  with done: misaligned or unsupported funct3
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word-aligned address, [1:0]=0
- dmem_wstrb  out  4  byte enables (0 for reads)
- dmem_wdata  out  32  lane-replicated store data
- dmem_gnt  in  1  request accepted when dmem_req & dmem_gnt
- dmem_rdata  in  32  read data, valid with dmem_rvalid
- dmem_rvalid  in  1  response (read data or write ack), exactly one per granted request

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: if in_valid & (mem_read|mem_write): capture addr, store_data, funct3, direction. Legal -> REQ; misaligned/illegal -> DONE with err=1. Otherwise stay.
- Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=0. Illegal: funct3 011/110/111 for loads; any funct3 other than 000/001/010 for stores.
- REQ: dmem_req=1, all dmem_* held stable until gnt. On gnt -> WAIT.
- WAIT: dmem_req=0. On rvalid: capture dmem_rdata -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- Stores: SB wdata={4{d[7:0]}}, wstrb=0001<<a[1:0]; SH wdata={2{d[15:0]}}, wstrb=0011<<a[1:0]; SW wdata=d, wstrb=1111.
- Loads: byte/half taken from rdata >> (8*a[1:0]); B/H sign-extend, BU/HU zero-extend, W pass-through.
- load_data=0 for stores and err completions.
- flush in REQ before gnt: drop request -> IDLE, no done.
- flush in WAIT: set kill flag, still consume rvalid, then -> IDLE without done.
- flush in IDLE/DONE: ignored for the current cycle's done; in IDLE blocks acceptance that cycle.

## Timing
- Reset (async, any state): state IDLE, kill=0, stall=0, done=0, err=0, load_data=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wstrb=0, dmem_wdata=0.
- stall = (state ∈ {REQ, WAIT}) | (state==IDLE & in_valid & (mem_read|mem_write) & !flush). stall=0 in DONE, so the pipeline advances on the done cycle.
- Best case: accept T, req T+1 with gnt, rvalid T+2, done T+3. Stall is high T..T+2.
- Error path: accept T, done+err T+1.
- A new access may be accepted in the IDLE cycle directly following DONE.
- rvalid in the same cycle as gnt is not supported; the bus guarantees at least one cycle gap.
- All outputs except stall are registered or decoded from registered state.

## Structure
- definitions.sv gains `LSU_B/H/W/BU/HU` funct3 constants and the `LSU_IDLE/REQ/WAIT/DONE` state encodings.
- Sub-module lsu_align (combinational): from size/addr[1:0]/store_data/rdata produces wstrb, wdata, and extended load value. It is shared by the request and response paths.
- mem_lsu holds the FSM, capture registers, and kill flag.

## Test plan
- LW addr=0x100, gnt immediate, rdata=0xDEADBEEF -> dmem_addr=0x100, wstrb=0, done at T+3, load_data=0xDEADBEEF, err=0.
- LB addr=0x103, rdata=0x80FF1234 -> load_data=0xFFFFFF80; LBU same -> 0x00000080; LHU addr=0x102 -> 0x000080FF.
- SH addr=0x202, store_data=0x1234ABCD -> dmem_we=1, dmem_addr=0x200, wstrb=1100, wdata=0xABCDABCD. Hold gnt low 3 cycles -> req/addr/wdata stable, stall held.
- LW addr=0x101 -> no dmem_req ever, done+err at T+1, load_data=0.
- flush in WAIT, then rvalid -> no done pulse, FSM IDLE, next LW accepted normally.
- Assert rst_n=0 while in REQ -> dmem_req drops immediately (async), all outputs at reset values, FSM IDLE after release.
